// File: rtl/cq_pkg.sv
// Shared defaults, the queue entry record and sizing helpers for the condition-queue issue scheduler.
package cq_pkg;

  localparam int CQ_DEPTH           = 8;
  localparam int CQ_DATA_WIDTH      = 32;
  localparam int CQ_CONDITION_WIDTH = 2;
  localparam int CQ_INDEX_WIDTH     = 4;

  typedef struct packed {
    logic [CQ_DATA_WIDTH-1:0]      data;
    logic [CQ_CONDITION_WIDTH-1:0] condition;
    logic [CQ_INDEX_WIDTH-1:0]     index;
  } cq_entry_t;

  function automatic int cq_occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cq_age_select.sv
// Oldest-ready selection: grants the ready slot that no other ready slot is older than.
module cq_age_select
  import cq_pkg::*;
#(
  parameter int DEPTH = CQ_DEPTH
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] older,
  output logic [DEPTH-1:0]            grant,
  output logic                        grant_valid
);

  logic [DEPTH-1:0] blocked;

  // older[j][i] set means j was allocated before i; stale rows of free slots are masked by ready.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i) begin
          blocked[i] = blocked[i] | (ready[j] & older[j][i]);
        end
      end
    end
    grant       = ready & ~blocked;
    grant_valid = |ready;
  end

endmodule

// File: rtl/cqentry.sv
// One condition-queue storage slot: payload, tag and condition bits, ready once all conditions are set.
module cqentry
  import cq_pkg::*;
#(
  parameter int DATA_WIDTH      = CQ_DATA_WIDTH,
  parameter int CONDITION_WIDTH = CQ_CONDITION_WIDTH,
  parameter int INDEX_WIDTH     = CQ_INDEX_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic                       valid_in,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [CONDITION_WIDTH-1:0] condition_in,
  input  logic [INDEX_WIDTH-1:0]     index_in,
  input  logic                       update_condition_valid,
  input  logic [CONDITION_WIDTH-1:0] update_condition_in,
  input  logic                       clear_entry,
  output logic                       valid_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [CONDITION_WIDTH-1:0] condition_out,
  output logic [INDEX_WIDTH-1:0]     index_out,
  output logic                       ready_to_dequeue_out
);

  logic                       valid_q, valid_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic [CONDITION_WIDTH-1:0] cond_q, cond_d;
  logic [INDEX_WIDTH-1:0]     index_q, index_d;

  // Clear beats a write beats a wakeup update.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cond_d  = cond_q;
    index_d = index_q;
    if (clear_entry) begin
      valid_d = 1'b0;
    end else if (wr_en) begin
      valid_d = valid_in;
      data_d  = data_in;
      cond_d  = condition_in;
      index_d = index_in;
    end else if (update_condition_valid) begin
      cond_d = update_condition_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cond_q  <= '0;
      index_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cond_q  <= cond_d;
      index_q <= index_d;
    end
  end

  assign valid_out            = valid_q;
  assign data_out             = data_q;
  assign condition_out        = cond_q;
  assign index_out            = index_q;
  assign ready_to_dequeue_out = valid_q & (&cond_q);

endmodule

// File: rtl/cq_issue_sched.sv
// Issue-stage condition queue: allocates slots on enqueue, applies tag wakeups, issues the oldest ready entry.
module cq_issue_sched
  import cq_pkg::*;
#(
  parameter int DEPTH           = CQ_DEPTH,
  parameter int DATA_WIDTH      = CQ_DATA_WIDTH,
  parameter int CONDITION_WIDTH = CQ_CONDITION_WIDTH,
  parameter int INDEX_WIDTH     = CQ_INDEX_WIDTH
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              flush,
  input  logic                              enq_valid,
  output logic                              enq_ready,
  input  logic [DATA_WIDTH-1:0]             enq_data,
  input  logic [CONDITION_WIDTH-1:0]        enq_condition,
  input  logic [INDEX_WIDTH-1:0]            enq_index,
  input  logic                              wakeup_valid,
  input  logic [INDEX_WIDTH-1:0]            wakeup_index,
  input  logic [CONDITION_WIDTH-1:0]        wakeup_mask,
  output logic                              deq_valid,
  input  logic                              deq_ready,
  output logic [DATA_WIDTH-1:0]             deq_data,
  output logic [INDEX_WIDTH-1:0]            deq_index,
  output logic [cq_occ_width(DEPTH)-1:0]    occupancy
);

  localparam int OCC_W = cq_occ_width(DEPTH);

  logic [DEPTH-1:0]           slot_valid, slot_ready;
  logic [DEPTH-1:0]           wr_en, clear, upd_valid, alloc, grant;
  logic [DATA_WIDTH-1:0]      slot_data [DEPTH];
  logic [CONDITION_WIDTH-1:0] slot_cond [DEPTH];
  logic [INDEX_WIDTH-1:0]     slot_index [DEPTH];
  logic [CONDITION_WIDTH-1:0] upd_cond [DEPTH];
  logic [CONDITION_WIDTH-1:0] enq_cond;
  logic                       any_ready, enq_fire, deq_fire;

  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
  logic [OCC_W-1:0]            occ_q, occ_d;

  // Lowest-numbered free slot; the descending loop lets the smallest index win.
  always_comb begin
    alloc = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!slot_valid[i]) begin
        alloc    = '0;
        alloc[i] = 1'b1;
      end
    end
  end

  assign enq_ready = (|(~slot_valid)) & ~flush;
  assign enq_fire  = enq_valid & enq_ready;
  assign enq_cond  = enq_condition |
                     ((wakeup_valid && (wakeup_index == enq_index)) ? wakeup_mask : '0);

  cq_age_select #(.DEPTH(DEPTH)) u_age_select (
    .ready       (slot_ready),
    .older       (older_q),
    .grant       (grant),
    .grant_valid (any_ready)
  );

  assign deq_valid = any_ready & ~flush;
  assign deq_fire  = deq_valid & deq_ready;

  always_comb begin
    deq_data  = '0;
    deq_index = '0;
    if (deq_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (grant[i]) begin
          deq_data  = deq_data | slot_data[i];
          deq_index = deq_index | slot_index[i];
        end
      end
    end
  end

  assign clear = {DEPTH{flush}} | ({DEPTH{deq_fire}} & grant);
  assign wr_en = {DEPTH{enq_fire}} & alloc;

  // A slot leaving this cycle must not also take a wakeup update.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      upd_valid[i] = wakeup_valid & slot_valid[i] & (slot_index[i] == wakeup_index) &
                     ~clear[i] & ~wr_en[i];
      upd_cond[i]  = slot_cond[i] | wakeup_mask;
    end
  end

  // New slot is younger than every survivor of this cycle.
  always_comb begin
    older_d = older_q;
    if (flush) begin
      older_d = '0;
    end else if (enq_fire) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc[k]) begin
          older_d[k] = '0;
          for (int i = 0; i < DEPTH; i++) begin
            older_d[i][k] = slot_valid[i] & ~clear[i];
          end
        end
      end
    end
  end

  always_comb begin
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(enq_fire) - OCC_W'(deq_fire);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      older_q <= '0;
      occ_q   <= '0;
    end else begin
      older_q <= older_d;
      occ_q   <= occ_d;
    end
  end

  assign occupancy = occ_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    cqentry #(
      .DATA_WIDTH      (DATA_WIDTH),
      .CONDITION_WIDTH (CONDITION_WIDTH),
      .INDEX_WIDTH     (INDEX_WIDTH)
    ) u_entry (
      .clock                  (clock),
      .reset_n                (reset_n),
      .wr_en                  (wr_en[g]),
      .valid_in               (1'b1),
      .data_in                (enq_data),
      .condition_in           (enq_cond),
      .index_in               (enq_index),
      .update_condition_valid (upd_valid[g]),
      .update_condition_in    (upd_cond[g]),
      .clear_entry            (clear[g]),
      .valid_out              (slot_valid[g]),
      .data_out               (slot_data[g]),
      .condition_out          (slot_cond[g]),
      .index_out              (slot_index[g]),
      .ready_to_dequeue_out   (slot_ready[g])
    );
  end

endmodule

// File: tb/tb_cq_issue_sched.sv
// Directed and randomized bench for cq_issue_sched against an age-ordered list model.
module tb_cq_issue_sched;
  import cq_pkg::*;

  localparam int DEPTH = 8;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_data;
  logic [1:0]  enq_condition;
  logic [3:0]  enq_index;
  logic        wakeup_valid;
  logic [3:0]  wakeup_index;
  logic [1:0]  wakeup_mask;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_data;
  logic [3:0]  deq_index;
  logic [3:0]  occupancy;

  int checks = 0;
  int errors = 0;

  logic        obs_er, obs_dv;
  logic [3:0]  obs_idx, obs_occ;

  // Reference: entries kept in allocation order; oldest ready is the first ready in the list.
  cq_entry_t mq[$];

  cq_issue_sched dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .flush         (flush),
    .enq_valid     (enq_valid),
    .enq_ready     (enq_ready),
    .enq_data      (enq_data),
    .enq_condition (enq_condition),
    .enq_index     (enq_index),
    .wakeup_valid  (wakeup_valid),
    .wakeup_index  (wakeup_index),
    .wakeup_mask   (wakeup_mask),
    .deq_valid     (deq_valid),
    .deq_ready     (deq_ready),
    .deq_data      (deq_data),
    .deq_index     (deq_index),
    .occupancy     (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sel_idx();
    for (int i = 0; i < mq.size(); i++)
      if (&mq[i].condition) return i;
    return -1;
  endfunction

  task automatic check_model();
    int s;
    logic        e_er, e_dv;
    logic [31:0] e_data;
    logic [3:0]  e_idx;
    s      = sel_idx();
    e_er   = !flush && (mq.size() < DEPTH);
    e_dv   = !flush && (s >= 0);
    e_data = e_dv ? mq[s].data : 32'h0;
    e_idx  = e_dv ? mq[s].index : 4'h0;
    chk("enq_ready", 32'(enq_ready), 32'(e_er));
    chk("deq_valid", 32'(deq_valid), 32'(e_dv));
    chk("deq_data", deq_data, e_data);
    chk("deq_index", 32'(deq_index), 32'(e_idx));
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    obs_er  = enq_ready;
    obs_dv  = deq_valid;
    obs_idx = deq_index;
    obs_occ = occupancy;
  endtask

  task automatic update_model();
    int        s;
    bit        can_enq;
    cq_entry_t e;
    if (flush) begin
      mq.delete();
    end else begin
      can_enq = enq_valid && (mq.size() < DEPTH);
      s = sel_idx();
      if (s >= 0 && deq_ready) mq.delete(s);
      if (wakeup_valid)
        for (int i = 0; i < mq.size(); i++)
          if (mq[i].index == wakeup_index)
            mq[i].condition = mq[i].condition | wakeup_mask;
      if (can_enq) begin
        e.data      = enq_data;
        e.condition = enq_condition |
                      ((wakeup_valid && enq_index == wakeup_index) ? wakeup_mask : 2'b00);
        e.index     = enq_index;
        mq.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_model();
    @(posedge clock);
    update_model();
    #1;
  endtask

  task automatic drive(input logic ev, input logic [1:0] ec, input logic [3:0] ei,
                       input logic wv, input logic [3:0] wi, input logic [1:0] wm,
                       input logic dr, input logic fl);
    enq_valid     = ev;
    enq_condition = ec;
    enq_index     = ei;
    enq_data      = $urandom;
    wakeup_valid  = wv;
    wakeup_index  = wi;
    wakeup_mask   = wm;
    deq_ready     = dr;
    flush         = fl;
    step();
  endtask

  task automatic idle(input logic dr);
    drive(1'b0, 2'b00, 4'h0, 1'b0, 4'h0, 2'b00, dr, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_enq_ready"}, 32'(enq_ready), 32'd1);
    chk({tag, "_deq_valid"}, 32'(deq_valid), 32'd0);
    chk({tag, "_deq_data"}, deq_data, 32'd0);
    chk({tag, "_deq_index"}, 32'(deq_index), 32'd0);
    chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    flush         = 1'b0;
    enq_valid     = 1'b0;
    enq_data      = '0;
    enq_condition = '0;
    enq_index     = '0;
    wakeup_valid  = 1'b0;
    wakeup_index  = '0;
    wakeup_mask   = '0;
    deq_ready     = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // In-order issue of three ready entries
    drive(1'b1, 2'b11, 4'd1, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
    chk("t1_not_same_cycle", 32'(obs_dv), 32'd0);
    drive(1'b1, 2'b11, 4'd2, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
    chk("t1_first_idx", 32'(obs_idx), 32'd1);
    drive(1'b1, 2'b11, 4'd3, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
    chk("t1_second_idx", 32'(obs_idx), 32'd2);
    idle(1'b1);
    chk("t1_third_idx", 32'(obs_idx), 32'd3);
    idle(1'b1);
    chk("t1_empty_occ", 32'(obs_occ), 32'd0);

    // Wakeup lets a younger ready entry go first
    drive(1'b1, 2'b00, 4'd5, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
    drive(1'b1, 2'b11, 4'd6, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
    drive(1'b0, 2'b00, 4'd0, 1'b1, 4'd5, 2'b11, 1'b1, 1'b0);
    chk("t2_young_first", 32'(obs_idx), 32'd6);
    idle(1'b1);
    chk("t2_woken_next", 32'(obs_idx), 32'd5);
    idle(1'b1);

    // Age order holds once both are ready
    drive(1'b1, 2'b01, 4'd5, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 4'd6, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 4'd0, 1'b1, 4'd5, 2'b10, 1'b0, 1'b0);
    idle(1'b1);
    chk("t2_age_first", 32'(obs_idx), 32'd5);
    idle(1'b1);
    chk("t2_age_second", 32'(obs_idx), 32'd6);
    idle(1'b1);

    // Full queue, no bypass, freed slot reused
    for (int k = 0; k < DEPTH; k++)
      drive(1'b1, 2'b11, 4'(k), 1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 4'd9, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
    chk("t3_full_enq_ready", 32'(obs_er), 32'd0);
    chk("t3_full_occ", 32'(obs_occ), 32'd8);
    drive(1'b1, 2'b11, 4'd10, 1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
    chk("t3_reopen_enq_ready", 32'(obs_er), 32'd1);
    idle(1'b0);
    chk("t3_refill_occ", 32'(obs_occ), 32'd8);
    for (int k = 0; k < DEPTH; k++) idle(1'b1);
    idle(1'b1);

    // Same-cycle enqueue and wakeup of one tag
    drive(1'b1, 2'b01, 4'd7, 1'b1, 4'd7, 2'b10, 1'b1, 1'b0);
    idle(1'b1);
    chk("t4_merged_valid", 32'(obs_dv), 32'd1);
    chk("t4_merged_idx", 32'(obs_idx), 32'd7);
    idle(1'b1);

    // Flush overrides enqueue and dequeue
    for (int k = 1; k <= 4; k++)
      drive(1'b1, 2'b11, 4'(k), 1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 2'b11, 4'd9, 1'b1, 4'd1, 2'b11, 1'b1, 1'b1);
    chk("t5_flush_enq_ready", 32'(obs_er), 32'd0);
    chk("t5_flush_deq_valid", 32'(obs_dv), 32'd0);
    idle(1'b1);
    chk("t5_post_flush_occ", 32'(obs_occ), 32'd0);

    // Asynchronous reset mid-stream
    for (int k = 1; k <= 3; k++)
      drive(1'b1, 2'b11, 4'(k + 10), 1'b0, 4'd0, 2'b00, 1'b0, 1'b0);
    enq_valid    = 1'b0;
    wakeup_valid = 1'b0;
    deq_ready    = 1'b0;
    flush        = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    mq.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    drive(1'b1, 2'b11, 4'd4, 1'b0, 4'd0, 2'b00, 1'b1, 1'b0);
    idle(1'b1);
    chk("t6_after_reset_idx", 32'(obs_idx), 32'd4);
    idle(1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 99) < 60), 2'($urandom), 4'($urandom_range(0, 3)),
            1'($urandom_range(0, 99) < 40), 4'($urandom_range(0, 3)), 2'($urandom),
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
